// File: rtl/mem_stream_arb.sv
// Arbitrates NCH first-word-fall-through memory ports into one registered
// {bx, sel, data} stream with valid/ready backpressure and optional BX headers.
module mem_stream_arb #(
    parameter int unsigned NCH    = 12,
    parameter int unsigned DW     = 45,
    parameter int unsigned BXW    = 3,
    parameter int unsigned SELW   = $clog2(NCH + 1),
    parameter int unsigned RR     = 0,
    parameter int unsigned HDR_EN = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [BXW-1:0]           bx,
    input  logic                     bx_start,
    input  logic [NCH*DW-1:0]        mem_dat,
    input  logic [NCH-1:0]           mem_valid,
    output logic [NCH-1:0]           mem_rd,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic                     out_hdr,
    output logic [BXW+SELW+DW-1:0]   mem_dat_stream
);

    localparam int unsigned     SW      = BXW + SELW + DW;
    localparam logic [SELW-1:0] HDR_SEL = '1;

    typedef enum logic {RUN, HDR_PEND} state_t;

    state_t          state, state_nxt;
    logic [BXW-1:0]  bx_cur, bx_cur_nxt;
    logic [DW-1:0]   word_cnt, word_cnt_nxt;
    logic [SELW-1:0] rr_ptr, rr_ptr_nxt;
    logic            out_valid_nxt, out_hdr_nxt;
    logic [SW-1:0]   stream_nxt;

    logic            load;
    logic            any_valid;
    logic [SELW-1:0] base;
    logic [2*NCH-1:0] dbl;
    logic [NCH-1:0]  rot;
    logic [SELW-1:0] off;
    logic [SELW:0]   gsum;
    logic [SELW-1:0] grant;
    logic [DW-1:0]   gnt_dat;

    assign load      = ~out_valid | out_ready;
    assign any_valid = |mem_valid;

    // Rotate the request vector so the search always starts at bit 0.
    assign base = (RR != 0) ? rr_ptr : '0;
    assign dbl  = {mem_valid, mem_valid} >> base;
    assign rot  = dbl[NCH-1:0];

    always_comb begin
        off = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (rot[i]) off = SELW'(i);
        end
    end

    always_comb begin
        gsum = {1'b0, base} + {1'b0, off};
        if (gsum >= (SELW+1)'(NCH)) gsum = gsum - (SELW+1)'(NCH);
    end

    assign grant = gsum[SELW-1:0];

    always_comb begin
        gnt_dat = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant == SELW'(i)) gnt_dat = mem_dat[i*DW +: DW];
        end
    end

    // Next-state, output-register and pop-strobe logic.
    always_comb begin
        state_nxt     = state;
        bx_cur_nxt    = bx_cur;
        word_cnt_nxt  = word_cnt;
        rr_ptr_nxt    = rr_ptr;
        out_valid_nxt = out_valid;
        out_hdr_nxt   = out_hdr;
        stream_nxt    = mem_dat_stream;
        mem_rd        = '0;

        if (bx_start) bx_cur_nxt = bx;

        case (state)
            HDR_PEND: begin
                if (load) begin
                    out_valid_nxt = 1'b1;
                    out_hdr_nxt   = 1'b1;
                    stream_nxt    = {bx_cur, HDR_SEL, word_cnt};
                    word_cnt_nxt  = '0;
                    state_nxt     = bx_start ? HDR_PEND : RUN;
                end
            end
            default: begin
                if (bx_start && (HDR_EN != 0)) begin
                    // Header pre-empts any data in the boundary cycle.
                    state_nxt = HDR_PEND;
                    if (load) begin
                        out_valid_nxt = 1'b0;
                        out_hdr_nxt   = 1'b0;
                    end
                end else if (load) begin
                    out_hdr_nxt   = 1'b0;
                    out_valid_nxt = any_valid;
                    if (any_valid) begin
                        stream_nxt   = {bx_cur_nxt, grant, gnt_dat};
                        mem_rd       = NCH'(rst_n) << grant;
                        word_cnt_nxt = (word_cnt == '1) ? word_cnt : word_cnt + DW'(1);
                        rr_ptr_nxt   = (grant == SELW'(NCH - 1)) ? '0 : grant + SELW'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bx_cur         <= '0;
            word_cnt       <= '0;
            rr_ptr         <= '0;
            out_valid      <= 1'b0;
            out_hdr        <= 1'b0;
            mem_dat_stream <= '0;
        end else begin
            bx_cur         <= bx_cur_nxt;
            word_cnt       <= word_cnt_nxt;
            rr_ptr         <= rr_ptr_nxt;
            out_valid      <= out_valid_nxt;
            out_hdr        <= out_hdr_nxt;
            mem_dat_stream <= stream_nxt;
        end
    end

endmodule
